req_code_sequencer: RTL

//  Upstream request stage for the 8x3 encoder datapath. Captures eight request lines into a sticky

---
 rtl/req_code_sequencer_pkg.sv | 23 ++
 rtl/req_code_sequencer_pick.sv | 43 ++++
 rtl/req_code_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/req_code_sequencer_pkg.sv
// req_seq_pkg -- shared types and helpers for the request code sequencer.
//   state_t    : presenter FSM states (ST_IDLE, ST_PRESENT)
//   N_REQ_DEF  : default number of request lines
//   CODE_W_DEF : default code width ($clog2(N_REQ_DEF))
//   onehot()   : expands a default-width code into a default-width one-hot mask
package req_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  localparam int unsigned N_REQ_DEF  = 8;
  localparam int unsigned CODE_W_DEF = 3;

  function automatic logic [N_REQ_DEF-1:0] onehot(input logic [CODE_W_DEF-1:0] code);
    logic [N_REQ_DEF-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/req_code_sequencer_pick.sv
// req_pick -- combinational circular priority search over a request vector.
//   Parameters: N_REQ (vector width), CODE_W (index width), DOWN (search direction)
//   i_vec   : candidate vector
//   i_start : first index examined; search wraps modulo N_REQ
//   o_code  : first set index in search order (0 when none)
//   o_any   : at least one bit of i_vec is set
// DOWN=1 with i_start=N_REQ-1 gives plain highest-index-wins priority.
module req_pick
  import req_seq_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned CODE_W = CODE_W_DEF,
  parameter bit          DOWN   = 1'b1
) (
  input  logic [N_REQ-1:0]  i_vec,
  input  logic [CODE_W-1:0] i_start,
  output logic [CODE_W-1:0] o_code,
  output logic              o_any
);

  always_comb begin : search
    int unsigned w_s;
    int unsigned w_idx;
    logic        w_found;
    w_s     = 32'(i_start);
    w_idx   = 0;
    w_found = 1'b0;
    o_code  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (DOWN) begin
        w_idx = (w_s + N_REQ - k) % N_REQ;
      end else begin
        w_idx = (w_s + k) % N_REQ;
      end
      if (!w_found && i_vec[w_idx]) begin
        w_found = 1'b1;
        o_code  = CODE_W'(w_idx);
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/req_code_sequencer.sv
// req_code_sequencer -- captures request lines into a sticky pending register and
// presents one pending request at a time as a binary code with valid/ready.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : request lines, level-sampled every edge
//   out_code  : index of the presented request (registered)
//   out_valid : out_code valid, held until accepted (registered)
//   out_ready : downstream accept
//   pending   : pending request register
//   ovf       : sticky flags for requests that re-fired while still pending
//   ovf_clr   : clears all ovf bits at the next edge (wins over a new set)
// Build option: define ROUND_ROBIN_EN for round-robin selection starting after the
// last accepted index; otherwise fixed priority, highest index wins.
module req_code_sequencer
  import req_seq_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned CODE_W = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_REQ-1:0]  pending,
  output logic [N_REQ-1:0]  ovf,
  input  logic              ovf_clr
);

  if (CODE_W != $clog2(N_REQ)) begin : g_bad_code_w
    $error("req_code_sequencer: CODE_W must equal $clog2(N_REQ)");
  end

  state_t              r_state;
  logic [CODE_W-1:0]   r_out_code;
  logic                r_out_valid;
  logic [N_REQ-1:0]    r_pending;
  logic [N_REQ-1:0]    r_ovf;

  logic                w_ack;
  logic [N_REQ-1:0]    w_oh;
  logic [N_REQ-1:0]    w_ack_mask;
  logic [CODE_W-1:0]   w_start;
  logic [CODE_W-1:0]   w_pick_code;
  logic                w_pick_any;

  assign w_ack = r_out_valid & out_ready;

  if (N_REQ == N_REQ_DEF && CODE_W == CODE_W_DEF) begin : g_oh_pkg
    assign w_oh = onehot(r_out_code);
  end else begin : g_oh_shift
    assign w_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_out_code;
  end

  assign w_ack_mask = w_ack ? w_oh : '0;

`ifdef ROUND_ROBIN_EN
  logic [CODE_W-1:0] r_rr_ptr;

  assign w_start = (r_rr_ptr == CODE_W'(N_REQ-1)) ? '0 : r_rr_ptr + 1'b1;

  req_pick #(
    .N_REQ  (N_REQ),
    .CODE_W (CODE_W),
    .DOWN   (1'b0)
  ) u_pick (
    .i_vec   (r_pending),
    .i_start (w_start),
    .o_code  (w_pick_code),
    .o_any   (w_pick_any)
  );
`else
  assign w_start = CODE_W'(N_REQ-1);

  req_pick #(
    .N_REQ  (N_REQ),
    .CODE_W (CODE_W),
    .DOWN   (1'b1)
  ) u_pick (
    .i_vec   (r_pending),
    .i_start (w_start),
    .o_code  (w_pick_code),
    .o_any   (w_pick_any)
  );
`endif

  // Set wins over ack: a bit re-requested on its ack edge stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_ack_mask) | req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else if (ovf_clr) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= r_ovf | (req & r_pending & ~w_ack_mask);
    end
  end

  // Selection looks at registered pending only, so a request sampled on this
  // edge becomes eligible one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_code  <= '0;
      r_out_valid <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_rr_ptr    <= CODE_W'(N_REQ-1);
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_out_code  <= w_pick_code;
            r_out_valid <= 1'b1;
            r_state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (w_ack) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
`ifdef ROUND_ROBIN_EN
            r_rr_ptr    <= r_out_code;
`endif
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_code  = r_out_code;
  assign out_valid = r_out_valid;
  assign pending   = r_pending;
  assign ovf       = r_ovf;

endmodule
